// File: rtl/mem_port_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arb_pkg
// Shared definitions for the memory port arbiter:
//   - arb_state_e      : 2-bit arbiter FSM encoding (IDLE/DRAIN/EXT_ADDR/EXT_DATA)
//   - MAX_WAIT_DEFAULT : default forced-grant wait limit in cycles
//   - mask_rdata()     : trims a read word to the access width (24 or 48 bits)
// -----------------------------------------------------------------------------
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_EXT_ADDR = 2'd2,
        ST_EXT_DATA = 2'd3
    } arb_state_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 8;

    // A 24-bit access only carries the low half; the upper half is forced to 0.
    function automatic logic [47:0] mask_rdata(input logic [47:0] data, input logic is48);
        logic [47:0] result;
        if (is48) begin
            result = data;
        end else begin
            result = {24'h000000, data[23:0]};
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arb_age_ctr.sv
// -----------------------------------------------------------------------------
// mem_arb_age_ctr
// Counts how long an external request has been waiting. Saturates at
// MAX_WAIT; o_sat flags that the limit has been reached.
// Ports:
//   iw_clk, iw_rst : clock, asynchronous active-high reset
//   i_inc          : request waiting this cycle
//   i_clr          : request granted or withdrawn (wins over i_inc)
//   o_sat          : counter equals MAX_WAIT
// -----------------------------------------------------------------------------
module mem_arb_age_ctr #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic iw_clk,
    input  logic iw_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

    logic [7:0] r_count;

    // Wait counter: clear has priority, increment stops at the limit.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_inc && (r_count != LP_MAX)) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_sat = (r_count == LP_MAX);

endmodule

// File: rtl/mem_port_arb.sv
// -----------------------------------------------------------------------------
// mem_port_arb
// Shares the two memory ports between the MA/MO pipeline stages and an
// external (debug/DMA) requester. MO uses port r_mp, MA the other one, and
// r_mp flips every non-stalled cycle. An external access takes the port the
// MO stage would not use, stalls the pipeline for two cycles (EXT_ADDR,
// EXT_DATA) and returns read data the cycle after EXT_DATA.
// Build option: define MEM_ARB_STARVE_GUARD_EN to add a wait counter that
// forces a grant (through a one-cycle DRAIN) after MAX_WAIT waiting cycles.
// Ports:
//   iw_clk, iw_rst                 clock, asynchronous active-high reset
//   iw_ma_mem_op, iw_mo_mem_op     pipeline stages hold a memory op
//   iw_ext_req/we/is48/addr/wdata  external request
//   iw_mem_rdata0/1                memory read buses
//   ow_mem_mp, ow_stall            MO port select, pipeline stall
//   ow_ext_gnt/port_en/port        grant, port mux steering, chosen port
//   ow_ext_addr/wdata/we/is48      captured external request
//   ow_ext_rvalid, ow_ext_rdata    external read return
// -----------------------------------------------------------------------------
module mem_port_arb
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic        iw_clk,
    input  logic        iw_rst,
    input  logic        iw_ma_mem_op,
    input  logic        iw_mo_mem_op,
    input  logic        iw_ext_req,
    input  logic        iw_ext_we,
    input  logic        iw_ext_is48,
    input  logic [47:0] iw_ext_addr,
    input  logic [47:0] iw_ext_wdata,
    input  logic [47:0] iw_mem_rdata0,
    input  logic [47:0] iw_mem_rdata1,
    output logic        ow_mem_mp,
    output logic        ow_stall,
    output logic        ow_ext_gnt,
    output logic        ow_ext_port_en,
    output logic        ow_ext_port,
    output logic [47:0] ow_ext_addr,
    output logic [47:0] ow_ext_wdata,
    output logic        ow_ext_we,
    output logic        ow_ext_is48,
    output logic        ow_ext_rvalid,
    output logic [47:0] ow_ext_rdata
);

    arb_state_e  r_state;
    arb_state_e  w_next_state;
    logic        r_mp;
    logic        r_ext_port;
    logic [47:0] r_ext_addr;
    logic [47:0] r_ext_wdata;
    logic        r_ext_we;
    logic        r_ext_is48;
    logic        r_rvalid;
    logic [47:0] r_rdata;
    logic        w_stall;
    logic        w_gnt;
    logic        w_port_en;
    logic        w_we_en;
    logic        w_force;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_age_inc;
    logic w_age_clr;
    logic w_age_sat;

    assign w_age_inc = (r_state == ST_IDLE) && iw_ext_req;
    assign w_age_clr = w_gnt || !iw_ext_req;

    mem_arb_age_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_ctr (
        .iw_clk (iw_clk),
        .iw_rst (iw_rst),
        .i_inc  (w_age_inc),
        .i_clr  (w_age_clr),
        .o_sat  (w_age_sat)
    );

    assign w_force = (r_state == ST_IDLE) && w_age_sat;
`else
    assign w_force = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state; a withdrawn request always falls back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iw_ext_req && w_force) begin
                    w_next_state = ST_DRAIN;
                end else if (iw_ext_req && !iw_ma_mem_op && !iw_mo_mem_op) begin
                    w_next_state = ST_EXT_ADDR;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (iw_ext_req) begin
                    w_next_state = ST_EXT_ADDR;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXT_ADDR: w_next_state = ST_EXT_DATA;
            ST_EXT_DATA: w_next_state = ST_IDLE;
            default:     w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        w_stall   = 1'b1;
        w_gnt     = 1'b0;
        w_port_en = 1'b0;
        w_we_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = 1'b0;
            end
            ST_DRAIN: begin
                w_stall = 1'b1;
            end
            ST_EXT_ADDR: begin
                w_gnt     = 1'b1;
                w_port_en = 1'b1;
            end
            ST_EXT_DATA: begin
                w_port_en = 1'b1;
                w_we_en   = r_ext_we;
            end
            default: begin
                w_stall = 1'b1;
            end
        endcase
    end

    // Port phase: flips every advancing cycle so MA/MO alternate ports.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_mp <= 1'b0;
        end else if (!w_stall) begin
            r_mp <= ~r_mp;
        end else begin
            r_mp <= r_mp;
        end
    end

    // Capture the request on entry to EXT_ADDR; it takes the port MO is not using.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_ext_addr  <= 48'h0;
            r_ext_wdata <= 48'h0;
            r_ext_we    <= 1'b0;
            r_ext_is48  <= 1'b0;
            r_ext_port  <= 1'b0;
        end else if (w_next_state == ST_EXT_ADDR) begin
            r_ext_addr  <= iw_ext_addr;
            r_ext_wdata <= iw_ext_wdata;
            r_ext_we    <= iw_ext_we;
            r_ext_is48  <= iw_ext_is48;
            r_ext_port  <= ~r_mp;
        end else begin
            r_ext_addr  <= r_ext_addr;
            r_ext_wdata <= r_ext_wdata;
            r_ext_we    <= r_ext_we;
            r_ext_is48  <= r_ext_is48;
            r_ext_port  <= r_ext_port;
        end
    end

    // Read return: sample the granted port in EXT_DATA, pulse valid next cycle.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 48'h0;
        end else if ((r_state == ST_EXT_DATA) && !r_ext_we) begin
            r_rvalid <= 1'b1;
            r_rdata  <= mask_rdata(r_ext_port ? iw_mem_rdata1 : iw_mem_rdata0, r_ext_is48);
        end else begin
            r_rvalid <= 1'b0;
            r_rdata  <= r_rdata;
        end
    end

    assign ow_mem_mp      = r_mp;
    assign ow_stall       = w_stall;
    assign ow_ext_gnt     = w_gnt;
    assign ow_ext_port_en = w_port_en;
    assign ow_ext_port    = r_ext_port;
    assign ow_ext_addr    = r_ext_addr;
    assign ow_ext_wdata   = r_ext_wdata;
    assign ow_ext_we      = w_we_en;
    assign ow_ext_is48    = r_ext_is48;
    assign ow_ext_rvalid  = r_rvalid;
    assign ow_ext_rdata   = r_rdata;

endmodule

// File: tb/tb_mem_port_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arb
// Directed bench for mem_port_arb. Stimulus pushes the expected grant and
// read-return records into queues; a monitor on the falling edge pops and
// compares them whenever the DUT shows ow_ext_gnt or ow_ext_rvalid.
// Expected cycles/ports/data are worked out by hand for the default
// MAX_WAIT=8, with separate contention numbers when MEM_ARB_STARVE_GUARD_EN
// is defined.
// -----------------------------------------------------------------------------
module tb_mem_port_arb;

    logic        iw_clk = 1'b0;
    logic        iw_rst;
    logic        iw_ma_mem_op, iw_mo_mem_op;
    logic        iw_ext_req, iw_ext_we, iw_ext_is48;
    logic [47:0] iw_ext_addr, iw_ext_wdata;
    logic [47:0] iw_mem_rdata0, iw_mem_rdata1;
    logic        ow_mem_mp, ow_stall, ow_ext_gnt, ow_ext_port_en, ow_ext_port;
    logic [47:0] ow_ext_addr, ow_ext_wdata;
    logic        ow_ext_we, ow_ext_is48, ow_ext_rvalid;
    logic [47:0] ow_ext_rdata;

    typedef struct {
        int          exp_cyc;
        logic        port;
        logic [47:0] addr;
        logic        is48;
        logic [47:0] wdata;
    } gnt_exp_t;

    typedef struct {
        int          exp_cyc;
        logic [47:0] data;
    } rd_exp_t;

    gnt_exp_t gnt_q[$];
    rd_exp_t  rd_q[$];
    int       total = 0;
    int       bad = 0;
    int       cyc;

    localparam logic [47:0] RD0 = 48'h111111222222;
    localparam logic [47:0] RD1 = 48'h5A5A5AABCDEF;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int          GNT_OFS = 10;
    localparam int          OPS_OFF = 10;
    localparam int          DRAIN_K = 9;
    localparam logic        CT_PORT = 1'b1;
    localparam logic [47:0] CT_DATA = RD1;
`else
    localparam int          GNT_OFS = 13;
    localparam int          OPS_OFF = 12;
    localparam int          DRAIN_K = 99;
    localparam logic        CT_PORT = 1'b0;
    localparam logic [47:0] CT_DATA = RD0;
`endif

    mem_port_arb dut (
        .iw_clk         (iw_clk),
        .iw_rst         (iw_rst),
        .iw_ma_mem_op   (iw_ma_mem_op),
        .iw_mo_mem_op   (iw_mo_mem_op),
        .iw_ext_req     (iw_ext_req),
        .iw_ext_we      (iw_ext_we),
        .iw_ext_is48    (iw_ext_is48),
        .iw_ext_addr    (iw_ext_addr),
        .iw_ext_wdata   (iw_ext_wdata),
        .iw_mem_rdata0  (iw_mem_rdata0),
        .iw_mem_rdata1  (iw_mem_rdata1),
        .ow_mem_mp      (ow_mem_mp),
        .ow_stall       (ow_stall),
        .ow_ext_gnt     (ow_ext_gnt),
        .ow_ext_port_en (ow_ext_port_en),
        .ow_ext_port    (ow_ext_port),
        .ow_ext_addr    (ow_ext_addr),
        .ow_ext_wdata   (ow_ext_wdata),
        .ow_ext_we      (ow_ext_we),
        .ow_ext_is48    (ow_ext_is48),
        .ow_ext_rvalid  (ow_ext_rvalid),
        .ow_ext_rdata   (ow_ext_rdata)
    );

    always #5 iw_clk = ~iw_clk;

    // Cycle index since the last reset release.
    always @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mp"},      64'(ow_mem_mp),      64'd0);
        chk({tag, "_stall"},   64'(ow_stall),       64'd0);
        chk({tag, "_gnt"},     64'(ow_ext_gnt),     64'd0);
        chk({tag, "_port_en"}, 64'(ow_ext_port_en), 64'd0);
        chk({tag, "_port"},    64'(ow_ext_port),    64'd0);
        chk({tag, "_addr"},    64'(ow_ext_addr),    64'd0);
        chk({tag, "_wdata"},   64'(ow_ext_wdata),   64'd0);
        chk({tag, "_we"},      64'(ow_ext_we),      64'd0);
        chk({tag, "_is48"},    64'(ow_ext_is48),    64'd0);
        chk({tag, "_rvalid"},  64'(ow_ext_rvalid),  64'd0);
        chk({tag, "_rdata"},   64'(ow_ext_rdata),   64'd0);
    endtask

    // Monitor: match every grant and read return against the queued expectations.
    always @(negedge iw_clk) begin
        if (!iw_rst) begin
            if (ow_ext_gnt) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", 64'd1, 64'd0);
                end else begin
                    gnt_exp_t g;
                    g = gnt_q.pop_front();
                    chk("gnt_cycle", 64'(cyc),         64'(g.exp_cyc));
                    chk("gnt_port",  64'(ow_ext_port), 64'(g.port));
                    chk("gnt_addr",  64'(ow_ext_addr), 64'(g.addr));
                    chk("gnt_is48",  64'(ow_ext_is48), 64'(g.is48));
                    chk("gnt_wdata", 64'(ow_ext_wdata), 64'(g.wdata));
                end
            end
            if (ow_ext_rvalid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk("rvalid_cycle", 64'(cyc),          64'(r.exp_cyc));
                    chk("rdata",        64'(ow_ext_rdata), 64'(r.data));
                end
            end
        end
    end

    // One external transaction with an idle pipeline; entered right after a rising edge.
    task automatic ext_txn(input logic [47:0] addr, input logic we, input logic is48,
                           input logic [47:0] wdata, input logic port, input logic [47:0] rdata);
        gnt_exp_t g;
        rd_exp_t  r;
        g.exp_cyc = cyc + 1; g.port = port; g.addr = addr; g.is48 = is48; g.wdata = wdata;
        gnt_q.push_back(g);
        if (!we) begin
            r.exp_cyc = cyc + 3; r.data = rdata;
            rd_q.push_back(r);
        end
        iw_ext_req = 1'b1; iw_ext_we = we; iw_ext_is48 = is48;
        iw_ext_addr = addr; iw_ext_wdata = wdata;
        @(negedge iw_clk);
        chk("txn_req_stall", 64'(ow_stall), 64'd0);
        @(posedge iw_clk); #1;
        iw_ext_req = 1'b0;
        @(negedge iw_clk);
        chk("txn_addr_stall", 64'(ow_stall),       64'd1);
        chk("txn_addr_pen",   64'(ow_ext_port_en), 64'd1);
        chk("txn_addr_we",    64'(ow_ext_we),      64'd0);
        chk("txn_addr_mp",    64'(ow_mem_mp),      64'(port));
        @(negedge iw_clk);
        chk("txn_data_stall", 64'(ow_stall),       64'd1);
        chk("txn_data_pen",   64'(ow_ext_port_en), 64'd1);
        chk("txn_data_we",    64'(ow_ext_we),      64'(we));
        chk("txn_data_gnt",   64'(ow_ext_gnt),     64'd0);
        @(negedge iw_clk);
        chk("txn_done_stall", 64'(ow_stall),       64'd0);
        chk("txn_done_pen",   64'(ow_ext_port_en), 64'd0);
        chk("txn_done_we",    64'(ow_ext_we),      64'd0);
        chk("txn_done_mp",    64'(ow_mem_mp),      64'(port));
        @(posedge iw_clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        gnt_exp_t g;
        rd_exp_t  r;
        iw_rst = 1'b1;
        iw_ma_mem_op = 1'b0; iw_mo_mem_op = 1'b0;
        iw_ext_req = 1'b0; iw_ext_we = 1'b0; iw_ext_is48 = 1'b0;
        iw_ext_addr = 48'h0; iw_ext_wdata = 48'h0;
        iw_mem_rdata0 = RD0; iw_mem_rdata1 = RD1;
        repeat (3) @(posedge iw_clk);
        @(negedge iw_clk);
        chk_all_zero("reset");
        @(posedge iw_clk); #1;
        iw_rst = 1'b0;

        // Free-running port phase with an idle pipeline.
        for (int i = 0; i < 6; i++) begin
            @(negedge iw_clk);
            chk("idle_mp",    64'(ow_mem_mp), 64'(i % 2));
            chk("idle_stall", 64'(ow_stall),  64'd0);
        end
        @(posedge iw_clk); #1;

        // Cycle 6, mp=0: 24-bit read takes port 1, upper half of data zeroed.
        ext_txn(48'h10, 1'b0, 1'b0, 48'h0, 1'b1, 48'h000000ABCDEF);
        // Cycle 10, mp=0: 48-bit write on port 1; read data must be held.
        ext_txn(48'h20, 1'b1, 1'b1, 48'h123456789ABC, 1'b1, 48'h0);
        chk("rdata_hold_after_write", 64'(ow_ext_rdata), 64'h000000ABCDEF);
        @(posedge iw_clk); #1;
        // Cycle 15, mp=1: 48-bit read on port 0.
        ext_txn(48'h30, 1'b0, 1'b1, 48'h0, 1'b0, RD0);

        // Contention: both stages busy while the external request waits (mp=1 here).
        c0 = cyc;
        g.exp_cyc = c0 + GNT_OFS; g.port = CT_PORT; g.addr = 48'h40; g.is48 = 1'b1; g.wdata = 48'h0;
        gnt_q.push_back(g);
        r.exp_cyc = c0 + GNT_OFS + 2; r.data = CT_DATA;
        rd_q.push_back(r);
        iw_ma_mem_op = 1'b1; iw_mo_mem_op = 1'b1;
        iw_ext_req = 1'b1; iw_ext_we = 1'b0; iw_ext_is48 = 1'b1; iw_ext_addr = 48'h40;
        repeat (GNT_OFS) begin
            @(negedge iw_clk);
            chk("contend_stall", 64'(ow_stall), 64'((cyc - c0) >= DRAIN_K));
            @(posedge iw_clk); #1;
            if ((cyc - c0) == OPS_OFF) begin
                iw_ma_mem_op = 1'b0; iw_mo_mem_op = 1'b0;
            end
        end
        iw_ext_req = 1'b0; iw_ma_mem_op = 1'b0; iw_mo_mem_op = 1'b0;
        repeat (3) @(posedge iw_clk);
        #1;

        // Request withdrawn while the pipeline holds the ports: never granted.
        iw_ma_mem_op = 1'b1; iw_ext_req = 1'b1; iw_ext_addr = 48'h50;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                iw_ext_req = 1'b0; iw_ma_mem_op = 1'b0;
            end
            @(negedge iw_clk);
            chk("abort_gnt",   64'(ow_ext_gnt), 64'd0);
            chk("abort_stall", 64'(ow_stall),   64'd0);
            @(posedge iw_clk); #1;
        end

        // Reset during EXT_DATA of a read (mp=1, so port 0 is granted).
        g.exp_cyc = cyc + 1; g.port = 1'b0; g.addr = 48'h77; g.is48 = 1'b0; g.wdata = 48'h0;
        gnt_q.push_back(g);
        iw_ext_req = 1'b1; iw_ext_we = 1'b0; iw_ext_is48 = 1'b0; iw_ext_addr = 48'h77;
        @(posedge iw_clk); #1;
        iw_ext_req = 1'b0;
        @(posedge iw_clk); #1;
        chk("pre_reset_in_data", 64'(ow_ext_port_en & ~ow_ext_gnt), 64'd1);
        #2 iw_rst = 1'b1;
        @(negedge iw_clk);
        chk_all_zero("midrst");
        @(posedge iw_clk); #1;
        iw_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iw_clk);
            chk("postrst_rvalid", 64'(ow_ext_rvalid), 64'd0);
            chk("postrst_stall",  64'(ow_stall),      64'd0);
            chk("postrst_mp",     64'(ow_mem_mp),     64'(i % 2));
        end

        chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        chk("rd_q_drained",  64'(rd_q.size()),  64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 8, meaning cycles an external request may wait before a forced grant (range 1..255).
REQ-002 SHALL have port iw_clk  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port iw_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports iw_ma_mem_op / iw_mo_mem_op  in  1 each  the MA / MO pipeline stage holds a memory op this cycle.
REQ-005 SHALL have ports iw_ext_req, iw_ext_we, iw_ext_is48  in  1 each  external (debug/DMA) request, write enable, and 48-bit access width.
REQ-006 SHALL have ports iw_ext_addr, iw_ext_wdata  in  48 each  external address and write data.
REQ-007 SHALL have ports iw_mem_rdata0, iw_mem_rdata1  in  48 each  memory read buses, port 0 and port 1.
REQ-008 SHALL have port ow_mem_mp  out  1  port the MO stage uses this cycle; MA uses the opposite port.
REQ-009 SHALL have port ow_stall  out  1  freezes pipeline advance into MA/MO.
REQ-010 SHALL have ports ow_ext_gnt, ow_ext_port_en, ow_ext_port  out  1 each  external grant; port mux steered to external; which port (0/1).
REQ-011 SHALL have ports ow_ext_addr, ow_ext_wdata  out  48 each, and ow_ext_we, ow_ext_is48  out  1 each  registered copies of the external request.
REQ-012 SHALL have ports ow_ext_rvalid  out  1 and ow_ext_rdata  out  48  external read return.

Function
REQ-013 SHALL keep register r_mp, toggling every cycle ow_stall=0 and holding when ow_stall=1; ow_mem_mp = r_mp.
REQ-014 SHALL implement FSM IDLE, DRAIN, EXT_ADDR, EXT_DATA; ow_stall=1 in every state except IDLE.
REQ-015 IDLE: iw_ext_req=1 with iw_ma_mem_op=0 and iw_mo_mem_op=0 SHALL go to EXT_ADDR; otherwise SHALL stay in IDLE with the pipeline having priority.
REQ-016 IDLE->EXT_ADDR SHALL capture iw_ext_addr/we/wdata/is48 into the ow_ext_* registers and set ow_ext_port = ~r_mp.
REQ-017 EXT_ADDR SHALL assert ow_ext_gnt and ow_ext_port_en for exactly that cycle and then go to EXT_DATA; the requester holds its inputs stable until ow_ext_gnt.
REQ-018 EXT_DATA SHALL keep ow_ext_port_en=1 on the same port, assert ow_ext_we if captured, capture the selected port's iw_mem_rdata (read only), and then go to IDLE.
REQ-019 ow_ext_rvalid SHALL pulse exactly one cycle, the cycle after EXT_DATA, for reads only; it SHALL be 0 for writes.
REQ-020 ow_ext_rdata SHALL hold the last read value until the next read; when ow_ext_is48=0 only bits [23:0] are meaningful, with [47:24] zeroed.
REQ-021 After EXT_DATA, at least one IDLE cycle SHALL pass before the next grant, so there are no back-to-back external transactions.
REQ-022 iw_ext_req dropping in IDLE or DRAIN SHALL abort to IDLE with no grant and no memory access.
REQ-023 Simultaneous iw_ext_req and pipeline ops without the forced condition SHALL give the pipeline the cycle and the external request SHALL wait.

Reset
REQ-024 Reset SHALL force state=IDLE, r_mp=0, wait counter=0, and all outputs 0, including ow_ext_rdata.
REQ-025 Reset asserted mid-transaction SHALL cancel it: no pending ow_ext_rvalid after release, and the first post-reset state is IDLE.

Configuration
REQ-026 With MEM_ARB_STARVE_GUARD_EN defined: the 8-bit wait counter SHALL increment per cycle while iw_ext_req=1 in IDLE without grant, saturate at MAX_WAIT, and clear on ow_ext_gnt or request drop.
REQ-027 With MEM_ARB_STARVE_GUARD_EN defined: counter==MAX_WAIT in IDLE SHALL force DRAIN regardless of pipeline ops; DRAIN lasts 1 cycle (stall, in-flight MO op completes) and then goes to EXT_ADDR.
REQ-028 Without MEM_ARB_STARVE_GUARD_EN: no counter SHALL exist, DRAIN SHALL be unreachable, and grants SHALL occur only per REQ-015.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (2-bit, IDLE=0, DRAIN=1, EXT_ADDR=2, EXT_DATA=3) and the default MAX_WAIT.
REQ-030 The wait counter SHALL be sub-module mem_arb_age_ctr, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-031 Pipeline idle, no ext request, 6 cycles -> ow_mem_mp = 0,1,0,1,0,1; ow_stall=0 throughout.
REQ-032 Idle pipeline, ext read of addr 0x10 (is48=0), mem returns 0xABCDEF -> gnt 1 cycle later, stall 2 cycles, then rvalid with rdata=0x000000ABCDEF.
REQ-033 Ext write, is48=1, wdata=0x123456789ABC -> ow_ext_we=1 in EXT_DATA only; ow_ext_rvalid stays 0; r_mp is the same before and after the stall.
REQ-034 Guard enabled, MAX_WAIT=8, continuous pipeline ops plus ext request -> DRAIN entered after 8 waiting cycles, gnt on the next cycle.
REQ-035 Guard disabled, same stimulus as REQ-034 -> no gnt while ops persist; gnt 1 cycle after the ops stop.
REQ-036 Reset pulse during EXT_DATA of a read -> no rvalid afterwards; all outputs 0; r_mp=0.
